simon_round_ctrl: RTL and testbench
===================================

# simon_round_ctrl

Round sequencer for the Simon block cipher core. Accepts a start/ctrl request, then drives the key-expansion unit and the round datapath through a fixed number of cycles, generating round-key RAM addresses ascending for encryption and descending for decryption. Sits between the top-level request FSM and the key RAM / round-function datapath. It owns the `busy`/`done` handshake.

## Interface
Parameters:
- `ROUNDS`, 44, number of Simon rounds (44 for Simon 64/128); legal range 2..255.
- `CW`, `$clog2(ROUNDS)`, round counter / key address width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `res_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `ctrl`  in  1  0 = encrypt, 1 = decrypt; sampled with `start`.
- `key_new`  in  1  1 = key input changed, force key expansion; sampled with `start`.
- `load`  out  1  datapath captures plaintext/ciphertext and key words.
- `kg_en`  out  1  key-expansion unit step enable.
- `kg_we`  out  1  round-key RAM write enable.
- `kg_addr`  out  CW  round-key RAM write address.
- `rnd_en`  out  1  round-function step enable.
- `rk_addr`  out  CW  round-key RAM read address.
- `dec_mode`  out  1  latched `ctrl`; selects word swap in datapath.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; result valid on datapath output.

## Operation
- One-hot FSM: IDLE, LOAD, KEYGEN, ROUND, DONE. Counter `cnt` (CW bits).
- IDLE: on `start`, latch `ctrl` into `dec_mode`, latch `key_new`; go LOAD. Otherwise stay.
- LOAD (1 cycle): `load`=1. Next: KEYGEN if key expansion required, else ROUND. `cnt` cleared.
- KEYGEN (ROUNDS cycles): `kg_en`=`kg_we`=1, `kg_addr`=`cnt`, `cnt` increments 0..ROUNDS-1; at `cnt`==ROUNDS-1 clear `cnt`, set key-valid flag, go ROUND.
- ROUND (ROUNDS cycles): `rnd_en`=1; `rk_addr`=`cnt` (encrypt) or ROUNDS-1-`cnt` (decrypt); at `cnt`==ROUNDS-1 go DONE.
- DONE (1 cycle): `done`=1; go IDLE.
- `start` outside IDLE ignored; `ctrl`/`key_new` changes while busy have no effect.
- All address outputs 0 when their enable is low.
- Key expansion required when `key_new`=1, or key-valid flag clear (see Configuration).

## Timing
- Reset (async, `res_n`=0): state IDLE, `cnt`=0, `dec_mode`=0, key-valid=0; all outputs 0.
- Reset release mid-operation: block restarts in IDLE; no `done` for the aborted request.
- `start` at edge N (in IDLE): LOAD in cycle N+1; KEYGEN N+2..N+ROUNDS+1; ROUND N+ROUNDS+2..N+2·ROUNDS+1; `done` in cycle N+2·ROUNDS+2; IDLE at N+2·ROUNDS+3.
- Keygen skipped: ROUND N+2..N+ROUNDS+1; `done` at N+ROUNDS+2.
- `start` in the DONE cycle is ignored; earliest accepted `start` is in the first IDLE cycle (back-to-back gap of 1 cycle).
- `cnt` wrap: never exceeds ROUNDS-1; compare is exact, no modulo arithmetic.

## Configuration
- `SIMON_KEY_CACHE_EN` defined: key-valid flag implemented; LOAD goes straight to ROUND when `key_new`=0 and key-valid=1. Flag cleared only by reset.
- Undefined: no flag; every request runs KEYGEN regardless of `key_new` (`key_new` unused).

## Test plan
- Reset: assert `res_n`=0 mid-ROUND -> same-cycle `busy`=0, all outputs 0; after release, `start` accepted normally.
- Encrypt, ROUNDS=44, `key_new`=1, `start` at cycle 0 -> `load` cycle 1, `kg_addr` 0..43 cycles 2..45, `rk_addr` 0..43 cycles 46..89, `done` cycle 90.
- Decrypt, `key_new`=1 -> `dec_mode`=1, `rk_addr` 43 down to 0 in cycles 46..89, `done` cycle 90.
- With `SIMON_KEY_CACHE_EN`: encrypt (`key_new`=1) then decrypt (`key_new`=0) -> second request has no `kg_en`, `rk_addr` 43..0 cycles 2..45, `done` cycle 46 after its `start`; without macro `done` at cycle 90.
- `start` held high through operation with `ctrl` toggling -> exactly one request executed, `dec_mode` constant, next request starts from first IDLE cycle.
- ROUNDS=2 boundary -> KEYGEN and ROUND each exactly 2 cycles, `done` at cycle 6.

Source files
------------

// File: rtl/simon_round_ctrl.sv
// Round sequencer for the Simon cipher core: LOAD -> optional KEYGEN -> ROUND -> DONE.
// Optional macro SIMON_KEY_CACHE_EN keeps a key-valid flag so unchanged keys skip KEYGEN.
module simon_round_ctrl #(
   parameter int ROUNDS = 44,
   parameter int CW     = $clog2(ROUNDS)
) (
   input  logic          clk,
   input  logic          res_n,
   input  logic          start,
   input  logic          ctrl,
   input  logic          key_new,
   output logic          load,
   output logic          kg_en,
   output logic          kg_we,
   output logic [CW-1:0] kg_addr,
   output logic          rnd_en,
   output logic [CW-1:0] rk_addr,
   output logic          dec_mode,
   output logic          busy,
   output logic          done
);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_LOAD   = 5'b00010,
      S_KEYGEN = 5'b00100,
      S_ROUND  = 5'b01000,
      S_DONE   = 5'b10000
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dec_q, dec_d;
   logic          need_kg;

`ifdef SIMON_KEY_CACHE_EN
   logic kn_q, kn_d;
   logic kv_q, kv_d;

   assign need_kg = kn_q | ~kv_q;
`else
   logic key_new_unused;

   assign key_new_unused = key_new;
   assign need_kg        = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
`ifdef SIMON_KEY_CACHE_EN
      kn_d    = kn_q;
      kv_d    = kv_q;
`endif
      load    = 1'b0;
      kg_en   = 1'b0;
      kg_we   = 1'b0;
      kg_addr = '0;
      rnd_en  = 1'b0;
      rk_addr = '0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               dec_d   = ctrl;
`ifdef SIMON_KEY_CACHE_EN
               kn_d    = key_new;
`endif
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = need_kg ? S_KEYGEN : S_ROUND;
         end
         S_KEYGEN: begin
            kg_en   = 1'b1;
            kg_we   = 1'b1;
            kg_addr = cnt_q;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
`ifdef SIMON_KEY_CACHE_EN
               kv_d    = 1'b1;
`endif
               state_d = S_ROUND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ROUND: begin
            rnd_en = 1'b1;
            // decryption consumes the round keys in reverse order
            rk_addr = dec_q ? (LAST - cnt_q) : cnt_q;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign dec_mode = dec_q;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
`ifdef SIMON_KEY_CACHE_EN
         kn_q    <= 1'b0;
         kv_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
`ifdef SIMON_KEY_CACHE_EN
         kn_q    <= kn_d;
         kv_q    <= kv_d;
`endif
      end
   end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: a 44-round and a 2-round instance driven by directed
// and random requests, each cycle checked against a cycle-offset timeline model.
module tb_simon_round_ctrl;

   logic clk = 1'b0;
   logic res_n = 1'b0;

   logic       start_a = 1'b0, ctrl_a = 1'b0, key_new_a = 1'b0;
   logic       load_a, kg_en_a, kg_we_a, rnd_en_a, dec_mode_a, busy_a, done_a;
   logic [5:0] kg_addr_a, rk_addr_a;

   logic       start_b = 1'b0, ctrl_b = 1'b0, key_new_b = 1'b0;
   logic       load_b, kg_en_b, kg_we_b, rnd_en_b, dec_mode_b, busy_b, done_b;
   logic [0:0] kg_addr_b, rk_addr_b;

   int n_assert = 0;
   int n_fail   = 0;
   bit kv_a = 1'b0, kv_b = 1'b0;

   always #5 clk = ~clk;

   simon_round_ctrl #(.ROUNDS(44)) dut_a (
      .clk(clk), .res_n(res_n), .start(start_a), .ctrl(ctrl_a), .key_new(key_new_a),
      .load(load_a), .kg_en(kg_en_a), .kg_we(kg_we_a), .kg_addr(kg_addr_a),
      .rnd_en(rnd_en_a), .rk_addr(rk_addr_a), .dec_mode(dec_mode_a),
      .busy(busy_a), .done(done_a)
   );

   simon_round_ctrl #(.ROUNDS(2)) dut_b (
      .clk(clk), .res_n(res_n), .start(start_b), .ctrl(ctrl_b), .key_new(key_new_b),
      .load(load_b), .kg_en(kg_en_b), .kg_we(kg_we_b), .kg_addr(kg_addr_b),
      .rnd_en(rnd_en_b), .rk_addr(rk_addr_b), .dec_mode(dec_mode_b),
      .busy(busy_b), .done(done_b)
   );

   // {load, kg_en, kg_we, kg_addr[7:0], rnd_en, rk_addr[7:0], dec_mode, busy, done}
   function automatic logic [22:0] obs(input int sel);
      if (sel == 0)
         return {load_a, kg_en_a, kg_we_a, 8'(kg_addr_a), rnd_en_a, 8'(rk_addr_a),
                 dec_mode_a, busy_a, done_a};
      return {load_b, kg_en_b, kg_we_b, 8'(kg_addr_b), rnd_en_b, 8'(rk_addr_b),
              dec_mode_b, busy_b, done_b};
   endfunction

   // Expected outputs t cycles after the accepting edge of a request.
   function automatic logic [22:0] model(input int r, input int t, input logic dec,
                                         input logic kg, input int rs);
      logic ld, ke, re, bz, dn;
      int   ka, ra;
      ld = (t == 1);
      ke = kg && (t >= 2) && (t <= r + 1);
      ka = ke ? t - 2 : 0;
      re = (t >= rs) && (t < rs + r);
      ra = re ? (dec ? r - 1 - (t - rs) : t - rs) : 0;
      dn = (t == rs + r);
      bz = (t >= 1) && (t <= rs + r);
      return {ld, ke, ke, 8'(ka), re, 8'(ra), dec, bz, dn};
   endfunction

   task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic c, input logic k);
      if (sel == 0) begin
         start_a = s; ctrl_a = c; key_new_a = k;
      end else begin
         start_b = s; ctrl_b = c; key_new_b = k;
      end
   endtask

   function automatic logic need_kg(input int sel, input logic k);
`ifdef SIMON_KEY_CACHE_EN
      return k || !((sel == 0) ? kv_a : kv_b);
`else
      return 1'b1;
`endif
   endfunction

   // Issue one request; hold keeps start high with random ctrl/key_new while busy,
   // abort_t > 0 pulls reset right after that cycle's check.
   task automatic run(input string name, input int sel, input logic c, input logic k,
                      input bit hold, input int abort_t);
      int   r, rs, last;
      logic kg;
      r    = (sel == 0) ? 44 : 2;
      kg   = need_kg(sel, k);
      rs   = kg ? r + 2 : 2;
      last = rs + r + 1;
      drive(sel, 1'b1, c, k);
      @(posedge clk);
      #1;
      if (!hold) drive(sel, 1'b0, c, k);
      for (int t = 1; t <= last; t++) begin
         @(negedge clk);
         check($sformatf("%s t=%0d", name, t), obs(sel), model(r, t, c, kg, rs));
         if (abort_t == t) begin
            res_n = 1'b0;
            #1;
            check({name, " reset_a"}, obs(0), 23'd0);
            check({name, " reset_b"}, obs(1), 23'd0);
            kv_a = 1'b0;
            kv_b = 1'b0;
            @(negedge clk);
            res_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check($sformatf("%s post_reset %0d", name, i), obs(sel), 23'd0);
            end
            return;
         end
         if (hold) drive(sel, 1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      if (sel == 0) kv_a = 1'b1;
      else          kv_b = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      check("reset_a", obs(0), 23'd0);
      check("reset_b", obs(1), 23'd0);
      @(negedge clk);
      res_n = 1'b1;
      @(negedge clk);
      check("idle_a", obs(0), 23'd0);

      run("enc_kn1", 0, 1'b0, 1'b1, 1'b0, 0);
      run("dec_kn1", 0, 1'b1, 1'b1, 1'b0, 0);
      run("cache_enc", 0, 1'b0, 1'b1, 1'b0, 0);
      run("cache_dec", 0, 1'b1, 1'b0, 1'b0, 0);
      run("hold_start", 0, 1'b0, 1'b0, 1'b1, 0);
      run("after_hold", 0, 1'b1, 1'b0, 1'b0, 0);

      run("r2_enc", 1, 1'b0, 1'b1, 1'b0, 0);
      run("r2_dec", 1, 1'b1, 1'b0, 1'b0, 0);
      run("r2_dec_kn1", 1, 1'b1, 1'b1, 1'b0, 0);

      run("abort", 0, 1'b1, 1'b1, 1'b0, 44 + 2 + 10);
      run("after_abort", 0, 1'b0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 10; i++) begin
         int gap;
         gap = int'($urandom_range(3, 0));
         for (int g = 0; g < gap; g++) @(negedge clk);
         run($sformatf("rand%0d", i), int'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
